exp7_unidade_controle: RTL

EXP7_UNIDADE_CONTROLE -- requirements
Module: exp7_unidade_controle

---
 rtl/exp7_unidade_controle.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/exp7_unidade_controle.sv
// Purpose: Moore control FSM for the memory game (show sequence, read plays, judge result).
// Latency: one state transition per clock edge; every output decodes the current state only.
// Backpressure: none; the FSM holds in a wait state until its awaited condition arrives.
// Build option: define TIMEOUT_EN to enable the play-timeout path (fimT, contaT, timeout).
module exp7_unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimE,
    input  logic       fimRod,
    input  logic       fimT,
    input  logic       fimM,
    input  logic       jogada,
    input  logic       igual,
    input  logic       enderecoIgualRodada,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraRod,
    output logic       contaRod,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraM,
    output logic       contaM,
    output logic       zeraR,
    output logic       registraR,
    output logic       mostra_leds,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam logic [3:0] INICIAL        = 4'h0;
    localparam logic [3:0] PREPARACAO     = 4'h1;
    localparam logic [3:0] INICIO_RODADA  = 4'h2;
    localparam logic [3:0] MOSTRA         = 4'h3;
    localparam logic [3:0] PROXIMO_MOSTRA = 4'h4;
    localparam logic [3:0] ZERA_LEITURA   = 4'h5;
    localparam logic [3:0] ESPERA_JOGADA  = 4'h6;
    localparam logic [3:0] REGISTRA       = 4'h7;
    localparam logic [3:0] COMPARA        = 4'h8;
    localparam logic [3:0] PROXIMA_JOGADA = 4'h9;
    localparam logic [3:0] FIM_ACERTOU    = 4'hA;
    localparam logic [3:0] PROXIMA_RODADA = 4'hB;
    localparam logic [3:0] FIM_TIMEOUT    = 4'hD;
    localparam logic [3:0] FIM_ERROU      = 4'hE;

    logic [3:0] estado_q;
    logic [3:0] estado_d;

    // fimE is not needed for sequencing: the end of a display or play pass is
    // detected by address == round instead.
`ifdef TIMEOUT_EN
    logic unused_ok;
    assign unused_ok = &{1'b0, fimE};
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, fimE, fimT};
`endif

    // Next-state selection from the current state and the status inputs.
    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:        estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     estado_d = INICIO_RODADA;
            INICIO_RODADA:  estado_d = MOSTRA;
            MOSTRA: begin
                if (!fimM)                    estado_d = MOSTRA;
                else if (enderecoIgualRodada) estado_d = ZERA_LEITURA;
                else                          estado_d = PROXIMO_MOSTRA;
            end
            PROXIMO_MOSTRA: estado_d = MOSTRA;
            ZERA_LEITURA:   estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A play landing in the same cycle as the timeout still counts.
                if (jogada)    estado_d = REGISTRA;
`ifdef TIMEOUT_EN
                else if (fimT) estado_d = FIM_TIMEOUT;
`endif
                else           estado_d = ESPERA_JOGADA;
            end
            REGISTRA:       estado_d = COMPARA;
            COMPARA: begin
                if (!igual)                    estado_d = FIM_ERROU;
                else if (!enderecoIgualRodada) estado_d = PROXIMA_JOGADA;
                else if (fimRod)               estado_d = FIM_ACERTOU;
                else                           estado_d = PROXIMA_RODADA;
            end
            PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_d = INICIO_RODADA;
            FIM_ACERTOU:    estado_d = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:      estado_d = iniciar ? PREPARACAO : FIM_ERROU;
`ifdef TIMEOUT_EN
            FIM_TIMEOUT:    estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
            default:        estado_d = INICIAL;
        endcase
    end

    // State register with synchronous reset back to INICIAL.
    always_ff @(posedge clock) begin
        if (reset) estado_q <= INICIAL;
        else       estado_q <= estado_d;
    end

    // Output decode: pure function of the current state.
    always_comb begin
        zeraE       = 1'b0;
        contaE      = 1'b0;
        zeraRod     = 1'b0;
        contaRod    = 1'b0;
        zeraT       = 1'b0;
        contaT      = 1'b0;
        zeraM       = 1'b0;
        contaM      = 1'b0;
        zeraR       = 1'b0;
        registraR   = 1'b0;
        mostra_leds = 1'b0;
        acertou     = 1'b0;
        errou       = 1'b0;
        timeout     = 1'b0;
        pronto      = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                zeraE   = 1'b1;
                zeraRod = 1'b1;
                zeraR   = 1'b1;
                zeraT   = 1'b1;
                zeraM   = 1'b1;
            end
            INICIO_RODADA: begin
                zeraE = 1'b1;
                zeraM = 1'b1;
            end
            MOSTRA: begin
                mostra_leds = 1'b1;
                contaM      = 1'b1;
            end
            PROXIMO_MOSTRA: begin
                contaE = 1'b1;
                zeraM  = 1'b1;
            end
            ZERA_LEITURA: begin
                zeraE = 1'b1;
                zeraT = 1'b1;
            end
            ESPERA_JOGADA: begin
`ifdef TIMEOUT_EN
                contaT = 1'b1;
`endif
            end
            REGISTRA:       registraR = 1'b1;
            PROXIMA_JOGADA: begin
                contaE = 1'b1;
                zeraT  = 1'b1;
            end
            PROXIMA_RODADA: contaRod = 1'b1;
            FIM_ACERTOU: begin
                acertou = 1'b1;
                pronto  = 1'b1;
            end
            FIM_ERROU: begin
                errou  = 1'b1;
                pronto = 1'b1;
            end
`ifdef TIMEOUT_EN
            FIM_TIMEOUT: begin
                timeout = 1'b1;
                errou   = 1'b1;
                pronto  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule
